cbuf_write_ctrl: RTL and testbench

Front end of the channel circular buffer. It packs the 12-bit ADC sample stream into 128-bit DDR3 write words and drives a wrapping word address. On `acq_trig` it freezes the buffer after a programmed post-trigger length, then raises `acq_done`. It sits between the ADC deserializer and the DDR3 memory-interface write port of `channel_main_cbuf`.

---
 rtl/cbuf_pkg.sv | 24 ++
 rtl/cbuf_write_ctrl_if.sv | 27 ++
 rtl/cbuf_packer.sv | 54 +++++
 rtl/cbuf_write_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_cbuf_write_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbuf_pkg.sv
// Shared definitions for the channel circular-buffer write path:
// FSM state encodings, write-word geometry and the lane formatting helper.
package cbuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cbuf_state_t;

    localparam int CBUF_WORD_W   = 128;
    localparam int CBUF_LANES    = 8;
    localparam int CBUF_LANE_W   = 16;
    localparam int CBUF_SAMPLE_W = 12;

    // A 12-bit ADC sample occupies the low bits of its 16-bit lane; the top
    // nibble is always zero (no sign extension, the sample is raw ADC code).
    function automatic logic [CBUF_LANE_W-1:0] cbuf_lane(input logic [CBUF_SAMPLE_W-1:0] sample);
        return {{(CBUF_LANE_W-CBUF_SAMPLE_W){1'b0}}, sample};
    endfunction

endpackage

// File: rtl/cbuf_write_ctrl_if.sv
// Write port towards the DDR3 memory interface: one 128-bit word plus its
// word address, qualified by a valid/ready handshake.
interface cbuf_write_ctrl_if #(
    parameter int ADDR_W = 24
);
    import cbuf_pkg::*;

    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr;
    logic [CBUF_WORD_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/cbuf_packer.sv
// Sample packer: collects eight 12-bit samples into one 128-bit word.
// word_stb is a single-cycle combinational strobe in the cycle that carries
// the lane-7 sample, so the caller can register the word on that same edge.
module cbuf_packer
    import cbuf_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     s_valid,
    input  logic [CBUF_SAMPLE_W-1:0] s_data,
    output logic                     word_stb,
    output logic [CBUF_WORD_W-1:0]   word,
    output logic [2:0]               lane
);

    logic [2:0]             lane_cnt;
    logic [CBUF_LANE_W-1:0] hold_p0 [0:CBUF_LANES-2];
    logic                   take;

    assign take = en & s_valid & ~clr;

    // Lane counter: restarts on clr, advances per accepted sample, 7 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= 3'd0;
        end else if (clr) begin
            lane_cnt <= 3'd0;
        end else if (take) begin
            lane_cnt <= lane_cnt + 3'd1;
        end
    end

    // Lanes 0..6 are parked here; lane 7 bypasses straight into the word.
    always_ff @(posedge clk) begin
        if (take && lane_cnt != 3'd7) begin
            hold_p0[lane_cnt] <= cbuf_lane(s_data);
        end
    end

    // Assemble the full word from the parked lanes plus the live sample.
    always_comb begin
        word = '0;
        for (int k = 0; k < CBUF_LANES - 1; k++) begin
            word[CBUF_LANE_W*k +: CBUF_LANE_W] = hold_p0[k];
        end
        word[CBUF_LANE_W*(CBUF_LANES-1) +: CBUF_LANE_W] = cbuf_lane(s_data);
    end

    assign word_stb = take & (lane_cnt == 3'd7);
    assign lane     = lane_cnt;

endmodule

// File: rtl/cbuf_write_ctrl.sv
// Circular-buffer write controller: packs ADC samples into 128-bit words,
// writes them to a wrapping word address through a one-deep output register,
// and freezes the buffer POST_WORDS words after a trigger word.
module cbuf_write_ctrl
    import cbuf_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int BUF_WORDS  = 2**20,
    parameter int PRE_WORDS  = 256,
    parameter int POST_WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     acq_trig,
    input  logic                     s_valid,
    input  logic [CBUF_SAMPLE_W-1:0] s_data,
    cbuf_write_ctrl_if.master        wr,
    output logic [ADDR_W-1:0]        trig_addr,
    output logic [2:0]               trig_lane,
    output logic                     acq_done,
    output logic                     overflow,
    output logic [2:0]               state
);

    localparam int                FILL_CW   = $clog2(PRE_WORDS + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BUF_WORDS - 1);

    // Next address in the circular buffer.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + 1'b1;
    endfunction

    // Address of the last post-trigger word: trigger word + POST_WORDS,
    // modulo the buffer depth. POST_WORDS is expected to be below BUF_WORDS.
    function automatic logic [ADDR_W-1:0] addr_post(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + (ADDR_W+1)'(POST_WORDS);
        if (sum >= (ADDR_W+1)'(BUF_WORDS)) begin
            sum = sum - (ADDR_W+1)'(BUF_WORDS);
        end
        return sum[ADDR_W-1:0];
    endfunction

    cbuf_state_t            state_q;
    cbuf_state_t            state_d;
    logic                   trig_d_q;
    logic                   trig_pend_q;
    logic [FILL_CW-1:0]     fill_cnt_q;
    logic [ADDR_W-1:0]      load_addr_q;
    logic [ADDR_W-1:0]      trig_addr_q;
    logic [2:0]             trig_lane_q;
    logic                   overflow_q;

    logic                   vld_p1;
    logic [CBUF_WORD_W-1:0] data_p1;
    logic [ADDR_W-1:0]      addr_p1;

    logic                   pack_en;
    logic                   pk_stb;
    logic [CBUF_WORD_W-1:0] pk_word;
    logic [2:0]             pk_lane;

    logic                   trig_edge;
    logic                   trig_hit;
    logic                   accept;
    logic                   final_acc;
    logic                   load;
    logic                   drop;
    logic [ADDR_W-1:0]      stop_addr;

    assign pack_en = (state_q == ST_FILL) || (state_q == ST_ARMED) || (state_q == ST_POST);

    cbuf_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (arm),
        .en       (pack_en),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .word_stb (pk_stb),
        .word     (pk_word),
        .lane     (pk_lane)
    );

    // Event decode. arm overrides everything in its cycle: no trigger,
    // no load and no drop is recorded for the acquisition being abandoned.
    assign trig_edge = acq_trig & ~trig_d_q;
    assign accept    = vld_p1 & wr.wr_ready;
    assign stop_addr = addr_post(trig_addr_q);
    assign final_acc = (state_q == ST_POST) & accept & (addr_p1 == stop_addr);
    assign trig_hit  = (state_q == ST_ARMED) & (trig_edge | trig_pend_q) & s_valid & ~arm;
    // The word completing alongside the final accept belongs after the
    // frozen window, so it is not loaded.
    assign load      = pk_stb & (~vld_p1 | accept) & ~final_acc & ~arm;
    assign drop      = pk_stb & vld_p1 & ~accept & ~arm;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept && fill_cnt_q == FILL_CW'(PRE_WORDS - 1)) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        state_d = ST_POST;
                    end
                end
                ST_POST: begin
                    if (final_acc) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Trigger edge register and pending flag for an edge seen without a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d_q    <= 1'b0;
            trig_pend_q <= 1'b0;
        end else begin
            trig_d_q <= acq_trig;
            if (arm || trig_hit) begin
                trig_pend_q <= 1'b0;
            end else if (state_q == ST_ARMED && trig_edge && !s_valid) begin
                trig_pend_q <= 1'b1;
            end
        end
    end

    // Pre-trigger word counter, saturating at PRE_WORDS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q <= '0;
        end else if (arm) begin
            fill_cnt_q <= '0;
        end else if (state_q == ST_FILL && accept && fill_cnt_q != FILL_CW'(PRE_WORDS)) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
        end
    end

    // Address for the next word to enter the output register; dropped words
    // never reach the register, so they never consume an address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_addr_q <= '0;
        end else if (arm) begin
            load_addr_q <= '0;
        end else if (load) begin
            load_addr_q <= addr_inc(load_addr_q);
        end
    end

    // Trigger position: the packing word's future address and current lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_addr_q <= '0;
            trig_lane_q <= 3'd0;
        end else if (trig_hit) begin
            trig_addr_q <= load_addr_q;
            trig_lane_q <= pk_lane;
        end
    end

    // Sticky overflow flag, cleared only by a new acquisition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (arm) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // ---- stage p1: one-deep output register holding the word until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            addr_p1 <= '0;
        end else if (arm) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= pk_word;
            addr_p1 <= load_addr_q;
        end else if (accept) begin
            vld_p1  <= 1'b0;
        end
    end

    assign wr.wr_valid = vld_p1;
    assign wr.wr_data  = data_p1;
    assign wr.wr_addr  = addr_p1;
    assign trig_addr   = trig_addr_q;
    assign trig_lane   = trig_lane_q;
    assign acq_done    = (state_q == ST_DONE);
    assign overflow    = overflow_q;
    assign state       = state_q;

endmodule

// File: tb/tb_cbuf_write_ctrl.sv
// Directed bench for cbuf_write_ctrl with a 16-word buffer, 4 pre-trigger
// words and 6 post-trigger words. Sample i of a scenario is presented in
// relative cycle i; word w holds samples 8w..8w+7.
module tb_cbuf_write_ctrl;
    import cbuf_pkg::*;

    localparam int AW = 24;
    localparam int BW = 16;
    localparam int PW = 4;
    localparam int QW = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           arm;
    logic           acq_trig;
    logic           s_valid;
    logic [11:0]    s_data;
    logic [AW-1:0]  trig_addr;
    logic [2:0]     trig_lane;
    logic           acq_done;
    logic           overflow;
    logic [2:0]     state;

    cbuf_write_ctrl_if #(.ADDR_W(AW)) wif ();

    cbuf_write_ctrl #(
        .ADDR_W(AW), .BUF_WORDS(BW), .PRE_WORDS(PW), .POST_WORDS(QW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .acq_trig  (acq_trig),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .wr        (wif),
        .trig_addr (trig_addr),
        .trig_lane (trig_lane),
        .acq_done  (acq_done),
        .overflow  (overflow),
        .state     (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0]  acc_addr [$];
    logic [127:0]   acc_data [$];

    // Record every accepted word (inputs change just after posedge, so the
    // negedge view equals what the next posedge will see).
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wif.wr_valid === 1'b1 && wif.wr_ready === 1'b1) begin
            acc_addr.push_back(wif.wr_addr);
            acc_data.push_back(wif.wr_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=2000000", $time);
        $fatal(1);
    end

    function automatic logic [127:0] word_of(input int base);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[16*j +: 12] = 12'(base + j);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
        acc_addr.delete();
        acc_data.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; acq_trig = 1'b0; s_valid = 1'b0; s_data = '0;
        wif.wr_ready = 1'b0;
        #3;
        total++; if (wif.wr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", wif.wr_valid); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state); end
        total++; if (wif.wr_addr !== '0 || wif.wr_data !== '0) begin bad++; $display("FAIL rst_bus: addr %h data %h want 0", wif.wr_addr, wif.wr_data); end
        total++; if ({acq_done, overflow, trig_lane} !== 5'd0 || trig_addr !== '0) begin bad++; $display("FAIL rst_flags: done %b ovf %b tlane %0d taddr %h want 0", acq_done, overflow, trig_lane, trig_addr); end
        step(); step();
        rst_n = 1'b1;
        step(); step();
        total++; if (state !== 3'd0 || wif.wr_valid !== 1'b0) begin bad++; $display("FAIL idle_hold: state %0d valid %b want 0/0", state, wif.wr_valid); end
    endtask

    task automatic test_packing();
        arm_pulse();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL pack_state: got %0d want 1", state); end
        wif.wr_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1; s_data = 12'(i);
            step();
        end
        s_valid = 1'b0;
        total++; if (wif.wr_valid !== 1'b1) begin bad++; $display("FAIL pack_valid: got %b want 1", wif.wr_valid); end
        total++; if (wif.wr_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin bad++; $display("FAIL pack_data: got %h want 00080007000600050004000300020001", wif.wr_data); end
        total++; if (wif.wr_addr !== 24'd0) begin bad++; $display("FAIL pack_addr: got %0d want 0", wif.wr_addr); end
        step();
        total++; if (wif.wr_valid !== 1'b0) begin bad++; $display("FAIL pack_release: got %b want 0", wif.wr_valid); end
    endtask

    task automatic test_wrap();
        arm_pulse();
        wif.wr_ready = 1'b1;
        for (int i = 0; i < 144; i++) begin
            s_valid = 1'b1; s_data = 12'(i);
            step();
        end
        s_valid = 1'b0;
        step(); step();
        total++; if (acc_addr.size() != 18) begin bad++; $display("FAIL wrap_count: got %0d want 18", acc_addr.size()); end
        for (int k = 0; k < acc_addr.size() && k < 18; k++) begin
            total++; if (acc_addr[k] !== AW'(k % BW)) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, acc_addr[k], k % BW); end
            total++; if (acc_data[k] !== word_of(8*k)) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", k, acc_data[k], word_of(8*k)); end
        end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL wrap_state: got %0d want 2", state); end
    endtask

    // FILL ends at the 4th accept (word 3, end of cycle 32). Trigger on
    // sample 51 -> word 6 lane 3; last post word is address 6+6=12, loaded
    // end of cycle 103, accepted end of cycle 104, acq_done from cycle 105.
    task automatic test_trigger();
        logic seen_late;
        seen_late = 1'b0;
        arm_pulse();
        wif.wr_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            s_valid = 1'b1; s_data = 12'(i);
            acq_trig = (i >= 10 && i < 16) || (i >= 51 && i < 60) || (i >= 70);
            step();
            if (i >= 104 && wif.wr_valid !== 1'b0) seen_late = 1'b1;
            case (i)
                20: begin
                    total++; if (state !== 3'd1) begin bad++; $display("FAIL fill_trig_state: got %0d want 1", state); end
                end
                44: begin
                    total++; if (state !== 3'd2) begin bad++; $display("FAIL armed_state: got %0d want 2", state); end
                    total++; if (trig_addr !== '0) begin bad++; $display("FAIL fill_trig_latch: got %0d want 0", trig_addr); end
                end
                51: begin
                    total++; if (state !== 3'd3) begin bad++; $display("FAIL post_state: got %0d want 3", state); end
                    total++; if (trig_addr !== 24'd6) begin bad++; $display("FAIL trig_addr: got %0d want 6", trig_addr); end
                    total++; if (trig_lane !== 3'd3) begin bad++; $display("FAIL trig_lane: got %0d want 3", trig_lane); end
                end
                75: begin
                    total++; if (trig_addr !== 24'd6 || trig_lane !== 3'd3) begin bad++; $display("FAIL post_retrig: addr %0d lane %0d want 6/3", trig_addr, trig_lane); end
                end
                103: begin
                    total++; if (wif.wr_valid !== 1'b1 || wif.wr_addr !== 24'd12) begin bad++; $display("FAIL last_word: valid %b addr %0d want 1/12", wif.wr_valid, wif.wr_addr); end
                    total++; if (acq_done !== 1'b0) begin bad++; $display("FAIL done_early: got %b want 0", acq_done); end
                end
                104: begin
                    total++; if (acq_done !== 1'b1) begin bad++; $display("FAIL done_rise: got %b want 1", acq_done); end
                    total++; if (state !== 3'd4) begin bad++; $display("FAIL done_state: got %0d want 4", state); end
                end
                default: ;
            endcase
        end
        s_valid = 1'b0; acq_trig = 1'b0;
        step(); step();
        total++; if (seen_late !== 1'b0) begin bad++; $display("FAIL done_no_write: got %b want 0", seen_late); end
        total++; if (acc_addr.size() != 13) begin bad++; $display("FAIL trig_count: got %0d want 13", acc_addr.size()); end
        if (acc_addr.size() > 0) begin
            total++; if (acc_addr[acc_addr.size()-1] !== 24'd12) begin bad++; $display("FAIL trig_last_addr: got %0d want 12", acc_addr[acc_addr.size()-1]); end
        end
        total++; if (acq_done !== 1'b1) begin bad++; $display("FAIL done_level: got %b want 1", acq_done); end
    endtask

    // Word 0 held from cycle 8 while ready is low (cycles 0..19); word 1
    // completes at cycle 15 and is dropped. Accepted words: data 0,16,24,32,40
    // at contiguous addresses 0..4.
    task automatic test_backpressure();
        int bases [5];
        bases = '{0, 16, 24, 32, 40};
        arm_pulse();
        for (int i = 0; i < 48; i++) begin
            wif.wr_ready = (i >= 20);
            s_valid = 1'b1; s_data = 12'(i);
            step();
            if (i >= 7 && i <= 18) begin
                total++; if (wif.wr_valid !== 1'b1 || wif.wr_addr !== 24'd0 || wif.wr_data !== word_of(0)) begin bad++; $display("FAIL bp_hold@%0d: valid %b addr %0d data %h want 1/0/%h", i, wif.wr_valid, wif.wr_addr, wif.wr_data, word_of(0)); end
            end
            if (i == 14) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_early: got %b want 0", overflow); end
            end
            if (i == 15) begin
                total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_set: got %b want 1", overflow); end
            end
        end
        s_valid = 1'b0;
        step(); step();
        total++; if (acc_addr.size() != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", acc_addr.size()); end
        for (int k = 0; k < acc_addr.size() && k < 5; k++) begin
            total++; if (acc_addr[k] !== AW'(k) || acc_data[k] !== word_of(bases[k])) begin bad++; $display("FAIL bp_word[%0d]: addr %0d data %h want %0d/%h", k, acc_addr[k], acc_data[k], k, word_of(bases[k])); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_sticky: got %b want 1", overflow); end
    endtask

    // Drop word 1 again, so accepts are words 0,2,3,4 (ARMED from cycle 41).
    // Trigger on sample 44 -> address 4, lane 4. Re-arm at sample 54 together
    // with a fresh trigger edge.
    task automatic test_rearm();
        arm_pulse();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL arm_clr_ovf: got %b want 0", overflow); end
        for (int i = 0; i <= 54; i++) begin
            wif.wr_ready = (i >= 16);
            acq_trig = (i >= 44 && i < 48) || (i == 54);
            arm = (i == 54);
            s_valid = 1'b1; s_data = 12'(i);
            step();
            if (i == 44) begin
                total++; if (state !== 3'd3 || trig_addr !== 24'd4 || trig_lane !== 3'd4) begin bad++; $display("FAIL rearm_trig: state %0d addr %0d lane %0d want 3/4/4", state, trig_addr, trig_lane); end
            end
            if (i == 53) begin
                total++; if (overflow !== 1'b1 || state !== 3'd3) begin bad++; $display("FAIL rearm_pre: ovf %b state %0d want 1/3", overflow, state); end
            end
        end
        arm = 1'b0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL rearm_state: got %0d want 1", state); end
        total++; if (acq_done !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL rearm_flags: done %b ovf %b want 0/0", acq_done, overflow); end
        total++; if (wif.wr_valid !== 1'b0 || wif.wr_addr !== 24'd0) begin bad++; $display("FAIL rearm_bus: valid %b addr %0d want 0/0", wif.wr_valid, wif.wr_addr); end
        for (int j = 0; j < 8; j++) begin
            s_valid = 1'b1; s_data = 12'(12'h200 + j);
            step();
        end
        s_valid = 1'b0;
        total++; if (wif.wr_valid !== 1'b1 || wif.wr_addr !== 24'd0 || wif.wr_data !== word_of(12'h200)) begin bad++; $display("FAIL rearm_word: valid %b addr %0d data %h want 1/0/%h", wif.wr_valid, wif.wr_addr, wif.wr_data, word_of(12'h200)); end
        total++; if (trig_addr !== 24'd4 || trig_lane !== 3'd4 || state !== 3'd1) begin bad++; $display("FAIL rearm_no_latch: addr %0d lane %0d state %0d want 4/4/1", trig_addr, trig_lane, state); end
        step();
    endtask

    task automatic test_async_reset();
        acq_trig = 1'b0;
        arm_pulse();
        wif.wr_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            acq_trig = (i >= 40);
            s_valid = 1'b1; s_data = 12'(i);
            step();
        end
        total++; if (wif.wr_valid !== 1'b1 || state !== 3'd3) begin bad++; $display("FAIL arst_pre: valid %b state %0d want 1/3", wif.wr_valid, state); end
        rst_n = 1'b0;
        #2;
        total++; if (wif.wr_valid !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL arst_ctrl: valid %b state %0d want 0/0", wif.wr_valid, state); end
        total++; if (wif.wr_addr !== '0 || wif.wr_data !== '0 || trig_addr !== '0 || trig_lane !== 3'd0) begin bad++; $display("FAIL arst_data: addr %h data %h taddr %h tlane %0d want 0", wif.wr_addr, wif.wr_data, trig_addr, trig_lane); end
        total++; if (acq_done !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL arst_flags: done %b ovf %b want 0/0", acq_done, overflow); end
        s_valid = 1'b0; acq_trig = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_packing();
        test_wrap();
        test_trigger();
        test_backpressure();
        test_rearm();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
